cis_sequencer: RTL

CIS_SEQUENCER -- requirements
Module: cis_sequencer

---
 rtl/cis_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/cis_sequencer.sv
// cis_sequencer: plays per-line CIS control patterns after integration ends, repeated once per skipper pass.
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   integration                  high while integrating; its falling edge starts a sequence
//   pattern_data[i][b]           line i, bit b of the pattern (bit 0 driven first)
//   pattern_len, num_skips       bits per pass (0 or >MAX_LEN -> MAX_LEN), passes (0 -> 1)
//   idle_level                   idle levels of lines 1..N-1 (line 0 is PDrst)
//   abort                        only with CIS_SEQ_ABORT_EN: ends the sequence at once
//   signal                       control waveforms
//   running, pass_done, seq_done RUN flag, last-bit-of-pass pulse, last-bit-of-sequence pulse
//   pass_index                   zero-based current pass, 0 when idle
// Build option: define CIS_SEQ_ABORT_EN to add the abort port and its logic.
module cis_sequencer #(
    parameter int NUM_SIGNALS = 10,
    parameter int MAX_LEN     = 128,
    parameter int SKIP_W      = 8,
    localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                integration,
    input  logic [NUM_SIGNALS-1:0][MAX_LEN-1:0] pattern_data,
    input  logic [LEN_W-1:0]                    pattern_len,
    input  logic [SKIP_W-1:0]                   num_skips,
    input  logic [NUM_SIGNALS-1:0]              idle_level,
`ifdef CIS_SEQ_ABORT_EN
    input  logic                                abort,
`endif
    output logic [NUM_SIGNALS-1:0]              signal,
    output logic                                running,
    output logic                                pass_done,
    output logic                                seq_done,
    output logic [SKIP_W-1:0]                   pass_index
);
    localparam int IDX_W = $clog2(MAX_LEN);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                              state_q, state_d;
    logic                                int_q, int_d;
    logic [NUM_SIGNALS-1:0][MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]                    idx_q, idx_d, last_bit_q, last_bit_d;
    logic [SKIP_W-1:0]                   pass_q, pass_d, last_pass_q, last_pass_d;
    logic                                start, kill, bit_end, pass_end;
    logic [NUM_SIGNALS-1:0]              run_sig, idle_sig;

`ifdef CIS_SEQ_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        int_d       = integration;
        start       = int_q && !integration;
        bit_end     = idx_q == last_bit_q;
        pass_end    = pass_q == last_pass_q;
        running     = state_q == RUN;
        pass_done   = running && bit_end && !kill;
        seq_done    = pass_done && pass_end;
        pass_index  = pass_q;
        state_d     = state_q;
        pat_d       = pat_q;
        idx_d       = idx_q;
        pass_d      = pass_q;
        last_bit_d  = last_bit_q;
        last_pass_d = last_pass_q;
        if (state_q == IDLE) begin
            // abort in the same cycle as start keeps the block idle
            if (start && !kill) begin
                state_d     = RUN;
                pat_d       = pattern_data;
                idx_d       = '0;
                pass_d      = '0;
                last_bit_d  = (pattern_len == '0 || pattern_len > LEN_W'(MAX_LEN))
                              ? LEN_W'(MAX_LEN - 1) : pattern_len - 1'b1;
                last_pass_d = (num_skips == '0) ? '0 : num_skips - 1'b1;
            end
        end else if (kill || (bit_end && pass_end)) begin
            state_d = IDLE;
            idx_d   = '0;
            pass_d  = '0;
        end else if (bit_end) begin
            // next pass follows immediately and picks up the live pattern
            idx_d  = '0;
            pass_d = pass_q + 1'b1;
            pat_d  = pattern_data;
        end else begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_comb begin
        idle_sig    = idle_level;
        idle_sig[0] = ~(integration | int_q);
        for (int i = 0; i < NUM_SIGNALS; i++) run_sig[i] = pat_q[i][idx_q[IDX_W-1:0]];
        signal = running ? run_sig : idle_sig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            int_q       <= 1'b0;
            pat_q       <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            last_bit_q  <= '0;
            last_pass_q <= '0;
        end else begin
            state_q     <= state_d;
            int_q       <= int_d;
            pat_q       <= pat_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            last_bit_q  <= last_bit_d;
            last_pass_q <= last_pass_d;
        end
    end
endmodule
